// File: rtl/map_cfg_seq.sv
// Live mapper-switch sequencer: collects a shadow configuration from the MCU and
// commits it to sys_cfg while the mapper is held in reset, aligned to quiet M2 phases.
module map_cfg_seq #(
  parameter int CFG_BYTES = 16,
  parameter int RST_CYC   = 8,
  parameter int M2_TMO    = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_addr,
  input  logic [7:0]             cfg_di,
  input  logic                   commit_req,
  input  logic                   m2,
  output logic [8*CFG_BYTES-1:0] sys_cfg,
  output logic                   map_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   err_ovl
);

  localparam int TMO_W = (M2_TMO > 1) ? $clog2(M2_TMO + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(M2_TMO);
  localparam logic [7:0]       CNT_LAST = 8'(RST_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_A,
    S_HOLD,
    S_COPY,
    S_WAIT_B,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [TMO_W-1:0]       tmo_q;
  logic [7:0]             cnt_q;
  logic [8*CFG_BYTES-1:0] shadow_q;
  logic [8*CFG_BYTES-1:0] sys_cfg_q;
  logic                   map_rst_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_ovl_q;
  logic                   m2_s1_q;
  logic                   m2_s2_q;
  logic                   m2_prev_q;
  logic                   m2_fall;
  logic                   tmo_hit;

  // M2 is asynchronous; a fall is seen one cycle after it leaves the synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_s1_q   <= 1'b0;
      m2_s2_q   <= 1'b0;
      m2_prev_q <= 1'b0;
    end else begin
      m2_s1_q   <= m2;
      m2_s2_q   <= m2_s1_q;
      m2_prev_q <= m2_s2_q;
    end
  end

  assign m2_fall = m2_prev_q & ~m2_s2_q;
  assign tmo_hit = (tmo_q == TMO_LAST);

  // Shadow file accepts writes in every state; out-of-range indices match no byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (cfg_we) begin
      for (int b = 0; b < CFG_BYTES; b++) begin
        if (int'(cfg_addr) == b) shadow_q[8*b +: 8] <= cfg_di;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      cnt_q     <= '0;
      sys_cfg_q <= '0;
      map_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_ovl_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (commit_req) begin
            state_q   <= S_WAIT_A;
            map_rst_q <= 1'b1;
            busy_q    <= 1'b1;
            tmo_q     <= '0;
            err_ovl_q <= 1'b0;
          end
        end
        S_WAIT_A: begin
          tmo_q <= tmo_q + 1'b1;
          // A fall coinciding with the timeout is still a single advance.
          if (m2_fall || tmo_hit) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
          end
        end
        S_HOLD: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= S_COPY;
        end
        S_COPY: begin
          sys_cfg_q <= shadow_q;
          state_q   <= S_WAIT_B;
          tmo_q     <= '0;
        end
        S_WAIT_B: begin
          tmo_q <= tmo_q + 1'b1;
          if (m2_fall || tmo_hit) begin
            state_q   <= S_DONE;
            map_rst_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // DONE still counts as busy, so a request there is flagged and dropped.
      if (commit_req && (state_q != S_IDLE)) err_ovl_q <= 1'b1;
    end
  end

  assign sys_cfg = sys_cfg_q;
  assign map_rst = map_rst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_ovl = err_ovl_q;

endmodule

// File: doc/map_cfg_seq.md
Name: map_cfg_seq

Overview:
- Sequences live mapper switching for the mapper hub.
- Collects a new system configuration from the MCU into a shadow register file, then commits it atomically to the active `sys_cfg` bus.
- During the commit the selected mapper is held in reset, and both edges of the switch are aligned to a quiet CPU bus phase (M2 low).
- Sits between the MCU register interface and the `sys_cfg` input of the mapper hub.

Parameters:
- CFG_BYTES, 16: number of configuration bytes; `sys_cfg` width = 8*CFG_BYTES.
- RST_CYC, 8: clk cycles the mapper reset is held after the bus is quiet (1..255).
- M2_TMO, 1023: clk cycles to wait for an M2 falling edge before proceeding anyway (console off).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  shadow byte write strobe, one cycle
- cfg_addr  in  4  shadow byte index (0..CFG_BYTES-1)
- cfg_di  in  8  shadow write data
- commit_req  in  1  commit request pulse
- m2  in  1  CPU M2, asynchronous to clk
- sys_cfg  out  8*CFG_BYTES  active configuration; byte 0 = map_idx
- map_rst  out  1  mapper reset, active high
- busy  out  1  commit sequence in progress
- done  out  1  one-cycle pulse on completion
- err_ovl  out  1  sticky: commit_req arrived while busy; cleared by the next accepted commit_req

Behaviour:
- Reset (async, rst_n=0):
  - shadow and sys_cfg all zero, so map_idx=0 (nominal mapper).
  - map_rst=0, busy=0, done=0, err_ovl=0, state=IDLE, counters=0.
- M2 sync: 2-flop synchronizer plus a previous-value flop. m2_fall = prev&~sync. An M2 fall is detected 3 clk after the pin edge.
- Shadow writes:
  - cfg_we writes shadow[cfg_addr] on the next edge and is accepted in every state.
  - cfg_addr >= CFG_BYTES is ignored.
  - A write in the same cycle as COPY lands in the shadow only, not in sys_cfg.
- States:
  - IDLE: busy=0. commit_req -> WAIT_A: set map_rst=1 and busy=1, load tmo=0, clear err_ovl.
  - WAIT_A: tmo++ each cycle. m2_fall, or tmo==M2_TMO -> HOLD with cnt=0.
  - HOLD: cnt++ each cycle. cnt==RST_CYC-1 -> COPY.
  - COPY (exactly 1 cycle): sys_cfg <= shadow, all bytes on the same edge. -> WAIT_B with tmo=0.
  - WAIT_B: m2_fall or tmo==M2_TMO -> DONE. map_rst is cleared on the same edge.
  - DONE (1 cycle): done=1, busy=0 on exit. -> IDLE.
- sys_cfg changes only in COPY and never while map_rst=0.
- commit_req while busy: ignored, err_ovl<=1. The sequence in progress is unaffected.
- commit_req in the DONE cycle counts as busy and is ignored. It is accepted in IDLE on the following cycle.
- Simultaneous m2_fall and timeout: treated as a single event, with no double advance.
- Reset mid-sequence: all state returns to reset values immediately. sys_cfg=0 (mapper 0), even if COPY had already occurred.
- Minimum commit latency, commit_req to done:
  - 1 (IDLE->WAIT_A) + 1 (first m2_fall) + RST_CYC + 1 (COPY) + 1 (m2_fall) + 1 (DONE) cycles.
  - Plus the M2 waits.
- Worst case: 2*(M2_TMO+1) + RST_CYC + 3 cycles.

Test Plan:
- Reset then idle: release rst_n -> sys_cfg=0, map_rst=0, busy=0, done=0 for 100 cycles with no stimulus.
- Basic commit:
  - Stimulus: write shadow[0]=8'd228, shadow[1]=8'h5A; M2 at clk/12; pulse commit_req.
  - Required response: map_rst rises next cycle. sys_cfg byte0=228 and byte1=8'h5A appear only after an M2 fall plus 8 cycles. map_rst falls on the next M2 fall. done pulses once. Total latency within 2 M2 periods + 11.
- M2 stopped: m2 held at 1, commit -> WAIT_A and WAIT_B each time out after 1024 cycles. done arrives at cycle 2*1024+11. sys_cfg is updated.
- Overlap:
  - Stimulus: commit_req again during HOLD.
  - Required response: err_ovl=1, a single done pulse. A later commit_req in IDLE clears err_ovl and starts a new sequence.
- Write during sequence: cfg_we shadow[0]=8'd36 in the COPY cycle -> sys_cfg byte0 keeps its old value. The next commit applies 36.
- Reset mid-HOLD: rst_n=0 while map_rst=1 -> map_rst=0 and sys_cfg=0 immediately (asynchronous). No done pulse after release.
